// File: rtl/freq_display_pkg.sv
// freq_display_pkg: shared widths and band-power FSM encoding for the frequency display path
package freq_display_pkg;
    localparam int DATA_W  = 12;
    localparam int ACC_W   = 29;
    localparam int N_BANDS = 3;
    localparam int CNT_W   = 17;
    typedef enum logic [2:0] {IDLE, DIV1, DIV2, DIV3, DONE} bp_state_t;
endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider, one load cycle plus one cycle per quotient bit
module seq_divider #(
    parameter int DVD_W = 29,
    parameter int DVS_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVD_W-1:0] quotient,
    output logic             done
);
    localparam int IT_W = $clog2(DVD_W + 1);
    logic [DVD_W-1:0] quo_q, quo_d;
    logic [DVS_W-1:0] rem_q, rem_d, dvs_q, dvs_d;
    logic [IT_W-1:0]  it_q, it_d;
    logic             done_q, done_d;
    logic [DVS_W:0]   rem_sh, diff;
    always_comb begin
        rem_sh = {rem_q, quo_q[DVD_W-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        quo_d  = start ? dividend : it_q != '0 ? {quo_q[DVD_W-2:0], ~diff[DVS_W]} : quo_q;
        rem_d  = start ? '0 : it_q == '0 ? rem_q : diff[DVS_W] ? rem_sh[DVS_W-1:0] : diff[DVS_W-1:0];
        dvs_d  = start ? divisor : dvs_q;
        it_d   = start ? IT_W'(DVD_W) : it_q != '0 ? it_q - 1'b1 : it_q;
        done_d = !start && it_q == IT_W'(1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            it_q   <= '0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            it_q   <= it_d;
            done_q <= done_d;
        end
    end
    assign quotient = dvs_q == '0 ? '0 : quo_q;
    assign done     = done_q;
endmodule

// File: rtl/band_power_calc.sv
// band_power_calc: per-window mean magnitude of three band-filter outputs for the display stage
module band_power_calc #(
    parameter int DATA_W = freq_display_pkg::DATA_W,
    parameter int ACC_W  = freq_display_pkg::ACC_W
) (
    input  logic              sample_clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] band1_in,
    input  logic [DATA_W-1:0] band2_in,
    input  logic [DATA_W-1:0] band3_in,
    input  logic              set_values_flag,
    output logic [DATA_W-1:0] bin1_out,
    output logic [DATA_W-1:0] bin2_out,
    output logic [DATA_W-1:0] bin3_out,
    output logic              bins_valid,
    output logic              busy,
    output logic              overrun
);
    import freq_display_pkg::*;
    bp_state_t         state_q, state_d;
    logic [DATA_W-1:0] band_in [N_BANDS];
    logic [DATA_W-1:0] mag [N_BANDS];
    logic [ACC_W:0]    sum [N_BANDS];
    logic [ACC_W-1:0]  acc_q [N_BANDS], acc_d [N_BANDS], hold_q [N_BANDS], hold_d [N_BANDS];
    logic [DATA_W-1:0] quot_q [N_BANDS], quot_d [N_BANDS], bin_q [N_BANDS], bin_d [N_BANDS];
    logic [CNT_W-1:0]  cnt_q, cnt_d, hold_cnt_q, hold_cnt_d;
    logic              bins_valid_q, bins_valid_d, overrun_q, overrun_d;
    logic              accept, dividing, div_start, div_done;
    logic [1:0]        cur;
    logic [ACC_W-1:0]  div_dividend, div_quot;
    logic [CNT_W-1:0]  div_divisor;
    logic [DATA_W-1:0] q_sat;

    assign band_in = '{band1_in, band2_in, band3_in};

    // Band 1 starts dividing straight from the live registers in the accept cycle
    always_comb begin
        accept       = set_values_flag && state_q == IDLE;
        dividing     = state_q inside {DIV1, DIV2, DIV3};
        cur          = state_q == DIV1 ? 2'd0 : state_q == DIV2 ? 2'd1 : 2'd2;
        div_start    = accept || (div_done && (state_q == DIV1 || state_q == DIV2));
        div_dividend = state_q == IDLE ? acc_q[0] : state_q == DIV1 ? hold_q[1] : hold_q[2];
        div_divisor  = state_q == IDLE ? cnt_q : hold_cnt_q;
        q_sat        = |div_quot[ACC_W-1:DATA_W] ? '1 : div_quot[DATA_W-1:0];
        cnt_d        = accept ? CNT_W'(sample_valid) : (sample_valid && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
        hold_cnt_d   = accept ? cnt_q : hold_cnt_q;
        for (int i = 0; i < N_BANDS; i++) begin
            mag[i]    = band_in[i][DATA_W-1] ? ~band_in[i] + 1'b1 : band_in[i];
            sum[i]    = {1'b0, acc_q[i]} + (ACC_W+1)'(mag[i]);
            acc_d[i]  = accept ? (sample_valid ? ACC_W'(mag[i]) : '0)
                      : !sample_valid ? acc_q[i] : sum[i][ACC_W] ? '1 : sum[i][ACC_W-1:0];
            hold_d[i] = accept ? acc_q[i] : hold_q[i];
            quot_d[i] = dividing && div_done && cur == 2'(i) ? q_sat : quot_q[i];
            bin_d[i]  = state_q == DONE ? quot_q[i] : bin_q[i];
        end
        bins_valid_d = state_q == DONE;
        overrun_d    = set_values_flag && state_q != IDLE;
        case (state_q)
            IDLE:    state_d = accept ? DIV1 : IDLE;
            DIV1:    state_d = div_done ? DIV2 : DIV1;
            DIV2:    state_d = div_done ? DIV3 : DIV2;
            DIV3:    state_d = div_done ? DONE : DIV3;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sample_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hold_cnt_q   <= '0;
            acc_q        <= '{default: '0};
            hold_q       <= '{default: '0};
            quot_q       <= '{default: '0};
            bin_q        <= '{default: '0};
            bins_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            acc_q        <= acc_d;
            hold_q       <= hold_d;
            quot_q       <= quot_d;
            bin_q        <= bin_d;
            bins_valid_q <= bins_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    seq_divider #(.DVD_W(ACC_W), .DVS_W(CNT_W)) u_div (
        .clk      (sample_clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .quotient (div_quot),
        .done     (div_done)
    );

    assign bin1_out   = bin_q[0];
    assign bin2_out   = bin_q[1];
    assign bin3_out   = bin_q[2];
    assign bins_valid = bins_valid_q;
    assign busy       = state_q != IDLE;
    assign overrun    = overrun_q;
endmodule
